// File: rtl/audio_pkg.sv
// Shared constants for the codec serial audio path: frame geometry and the
// DAC playback state encodings.
package audio_pkg;

    localparam int SAMPLE_W = 16;
    localparam int FRAME_W  = 32;
    localparam int CNT_W    = $clog2(SAMPLE_W);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_SEND_L = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_SEND_R = 3'd4;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/lrck_edge_detect.sv
// Registers the codec LR clock once and flags its edges against the live
// level; shared by the DAC and ADC sides.
module lrck_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic lrck,
    output logic rise,
    output logic fall
);

    logic pre_lrck_r;

    // One-cycle history of the LR clock (pre_LRCLK)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_lrck_r <= 1'b0;
        end else begin
            pre_lrck_r <= lrck;
        end
    end

    assign rise = ~pre_lrck_r &  lrck;
    assign fall =  pre_lrck_r & ~lrck;

endmodule

// File: rtl/dac_controller.sv
// Serializes buffered stereo samples MSB-first onto the codec DACDAT line,
// framed by DACLRCK, with underrun detection and a saturating underrun count.
module dac_controller
    import audio_pkg::*;
(
    input  logic        i_BCLK,
    input  logic        i_rst_n,
    input  logic        i_play,
    input  logic        i_DACLRCK,
    input  logic [31:0] i_DATA,
    input  logic        i_valid,
    output logic        o_ready,
    output logic        o_DACDAT,
    output logic        o_underrun,
    output logic [7:0]  o_underrun_cnt,
    output logic [2:0]  o_PLAY_STATE
);

    logic [2:0]         state_r;
    logic [2:0]         state_s;
    logic [FRAME_W-1:0] buf_r;
    logic [FRAME_W-1:0] buf_s;
    logic               buf_full_r;
    logic               buf_full_s;
    logic [FRAME_W-1:0] shift_r;
    logic [FRAME_W-1:0] shift_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_s;
    logic               dacdat_r;
    logic               dacdat_s;
    logic               underrun_r;
    logic               underrun_s;
    logic [7:0]         ucnt_r;
    logic [7:0]         ucnt_s;
    logic               start_s;
    logic               load_s;
    logic               rise_s;
    logic               fall_s;

    lrck_edge_detect u_lrck_edge (
        .clk   (i_BCLK),
        .rst_n (i_rst_n),
        .lrck  (i_DACLRCK),
        .rise  (rise_s),
        .fall  (fall_s)
    );

    // Playback FSM and serializer; a falling LRCK edge always opens a new frame
    always_comb begin
        state_s    = state_r;
        shift_s    = shift_r;
        cnt_s      = cnt_r;
        dacdat_s   = 1'b0;
        underrun_s = 1'b0;
        ucnt_s     = ucnt_r;
        start_s    = 1'b0;
        load_s     = 1'b0;
        if (!i_play) begin
            state_s = S_IDLE;
            cnt_s   = '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    state_s = S_WAIT;
                    cnt_s   = '0;
                end
                S_WAIT: begin
                    start_s = fall_s;
                end
                S_SEND_L: begin
                    if (cnt_r == LAST_BIT) begin
                        state_s = S_GAP;
                        cnt_s   = '0;
                    end else begin
                        dacdat_s = shift_r[FRAME_W-1];
                        shift_s  = {shift_r[FRAME_W-2:0], 1'b0};
                        cnt_s    = cnt_r + CNT_ONE;
                    end
                end
                S_GAP: begin
                    if (fall_s) begin
                        start_s = 1'b1;
                    end else if (rise_s) begin
                        state_s  = S_SEND_R;
                        dacdat_s = shift_r[FRAME_W-1];
                        shift_s  = {shift_r[FRAME_W-2:0], 1'b0};
                        cnt_s    = '0;
                    end else begin
                        state_s = S_GAP;
                    end
                end
                S_SEND_R: begin
                    // A short frame cuts the right channel; the rest is dropped
                    if (fall_s) begin
                        start_s = 1'b1;
                    end else if (cnt_r == LAST_BIT) begin
                        state_s = S_WAIT;
                        cnt_s   = '0;
                    end else begin
                        dacdat_s = shift_r[FRAME_W-1];
                        shift_s  = {shift_r[FRAME_W-2:0], 1'b0};
                        cnt_s    = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_s = S_IDLE;
                    cnt_s   = '0;
                end
            endcase
        end
        if (start_s) begin
            state_s = S_SEND_L;
            cnt_s   = '0;
            load_s  = buf_full_r;
            if (buf_full_r) begin
                dacdat_s = buf_r[FRAME_W-1];
                shift_s  = {buf_r[FRAME_W-2:0], 1'b0};
            end else begin
                shift_s    = '0;
                underrun_s = 1'b1;
                ucnt_s     = sat_inc8(ucnt_r);
            end
        end else begin
            load_s = 1'b0;
        end
    end

    // One-entry sample buffer: a frame start drains it, the handshake fills it
    always_comb begin
        buf_s      = buf_r;
        buf_full_s = buf_full_r;
        if (load_s) begin
            buf_full_s = 1'b0;
        end else if (i_valid && !buf_full_r) begin
            buf_s      = i_DATA;
            buf_full_s = 1'b1;
        end else begin
            buf_full_s = buf_full_r;
        end
    end

    // State, datapath and output registers
    always_ff @(posedge i_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= S_IDLE;
            buf_r      <= '0;
            buf_full_r <= 1'b0;
            shift_r    <= '0;
            cnt_r      <= '0;
            dacdat_r   <= 1'b0;
            underrun_r <= 1'b0;
            ucnt_r     <= 8'd0;
        end else begin
            state_r    <= state_s;
            buf_r      <= buf_s;
            buf_full_r <= buf_full_s;
            shift_r    <= shift_s;
            cnt_r      <= cnt_s;
            dacdat_r   <= dacdat_s;
            underrun_r <= underrun_s;
            ucnt_r     <= ucnt_s;
        end
    end

    assign o_ready        = ~buf_full_r;
    assign o_DACDAT       = dacdat_r;
    assign o_underrun     = underrun_r;
    assign o_underrun_cnt = ucnt_r;
    assign o_PLAY_STATE   = state_r;

endmodule

// File: tb/tb_dac_controller.sv
// Randomized self-checking bench for dac_controller; expected serial output
// comes from a frame-level model of the sample buffer and bit ordering.
module tb_dac_controller;

    logic        clk;
    logic        rst_n;
    logic        play;
    logic        lrck;
    logic [31:0] data;
    logic        valid;
    logic        ready;
    logic        dacdat;
    logic        underrun;
    logic [7:0]  ucnt;
    logic [2:0]  st;

    int          n_tests = 0;
    int          n_fail  = 0;

    bit          m_full  = 1'b0;
    logic [31:0] m_buf   = 32'h0;
    int          m_ucnt  = 0;

    dac_controller dut (
        .i_BCLK         (clk),
        .i_rst_n        (rst_n),
        .i_play         (play),
        .i_DACLRCK      (lrck),
        .i_DATA         (data),
        .i_valid        (valid),
        .o_ready        (ready),
        .o_DACDAT       (dacdat),
        .o_underrun     (underrun),
        .o_underrun_cnt (ucnt),
        .o_PLAY_STATE   (st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        bit          acc;
        logic [31:0] d;
        acc = valid && !m_full;
        d   = data;
        @(posedge clk);
        #1;
        if (acc) begin
            m_full = 1'b1;
            m_buf  = d;
            valid  = 1'b0;
        end
    endtask

    task automatic load_sample(input logic [31:0] d);
        int waited;
        waited = 0;
        valid  = 1'b1;
        data   = d;
        while (valid && waited < 50) begin
            tick();
            waited++;
        end
        n_tests++;
        if (valid !== 1'b0 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL load_sample: accepted=%0b ready=%b, required accepted=1 ready=0", !valid, ready);
            valid = 1'b0;
        end
    endtask

    // One LRCK frame: half_l cycles low then half_r cycles high
    task automatic run_frame(input int half_l, input int half_r, input bit give_nxt, input logic [31:0] nxt);
        logic [31:0] smp;
        bit          pre_full;
        logic        exp_bit;
        pre_full = m_full;
        smp      = pre_full ? m_buf : 32'h0;
        lrck     = 1'b0;
        for (int i = 1; i <= half_l; i++) begin
            tick();
            if (i == 1) begin
                if (pre_full) m_full = 1'b0;
                else m_ucnt = (m_ucnt < 255) ? m_ucnt + 1 : 255;
                n_tests++;
                if (underrun !== !pre_full) begin
                    n_fail++;
                    $display("FAIL underrun_pulse: got %b required %b", underrun, !pre_full);
                end
                n_tests++;
                if (ucnt !== 8'(m_ucnt)) begin
                    n_fail++;
                    $display("FAIL underrun_cnt: got %0d required %0d", ucnt, m_ucnt);
                end
                n_tests++;
                if (st !== 3'd2) begin
                    n_fail++;
                    $display("FAIL state_send_l: got %0d required 2", st);
                end
            end else begin
                n_tests++;
                if (underrun !== 1'b0) begin
                    n_fail++;
                    $display("FAIL underrun_idle: left i=%0d got %b required 0", i, underrun);
                end
            end
            if (i == 17) begin
                n_tests++;
                if (st !== 3'd3) begin
                    n_fail++;
                    $display("FAIL state_gap: got %0d required 3", st);
                end
            end
            if (i <= 16) exp_bit = smp[32-i];
            else exp_bit = 1'b0;
            n_tests++;
            if (dacdat !== exp_bit) begin
                n_fail++;
                $display("FAIL left_bit: sample %h i=%0d got %b required %b", smp, i, dacdat, exp_bit);
            end
            n_tests++;
            if (ready !== (m_full ? 1'b0 : 1'b1)) begin
                n_fail++;
                $display("FAIL ready_left: i=%0d got %b required %b", i, ready, !m_full);
            end
            if (give_nxt && i == 2) begin
                valid = 1'b1;
                data  = nxt;
            end
        end
        lrck = 1'b1;
        for (int i = 1; i <= half_r; i++) begin
            tick();
            if (i == 1) begin
                n_tests++;
                if (st !== 3'd4) begin
                    n_fail++;
                    $display("FAIL state_send_r: got %0d required 4", st);
                end
            end
            if (i == 17) begin
                n_tests++;
                if (st !== 3'd1) begin
                    n_fail++;
                    $display("FAIL state_wait: got %0d required 1", st);
                end
            end
            if (i <= 16) exp_bit = smp[16-i];
            else exp_bit = 1'b0;
            n_tests++;
            if (dacdat !== exp_bit || underrun !== 1'b0) begin
                n_fail++;
                $display("FAIL right_bit: sample %h i=%0d got %b/%b required %b/0", smp, i, dacdat, underrun, exp_bit);
            end
            n_tests++;
            if (ready !== (m_full ? 1'b0 : 1'b1)) begin
                n_fail++;
                $display("FAIL ready_right: i=%0d got %b required %b", i, ready, !m_full);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        play  = 1'b0;
        lrck  = 1'b1;
        valid = 1'b0;
        data  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (st !== 3'd0 || ready !== 1'b1 || dacdat !== 1'b0 || underrun !== 1'b0 || ucnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_values: st=%0d ready=%b dacdat=%b underrun=%b cnt=%0d required 0,1,0,0,0",
                     st, ready, dacdat, underrun, ucnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        play = 1'b1;
        tick();
        n_tests++;
        if (st !== 3'd1) begin
            n_fail++;
            $display("FAIL state_idle_to_wait: got %0d required 1", st);
        end
        load_sample(32'hA5A5_3C3C);
        run_frame(20, 20, 1'b0, 32'h0);
    endtask

    task automatic test_underrun();
        run_frame(20, 20, 1'b0, 32'h0);
        n_tests++;
        if (ucnt !== 8'd1) begin
            n_fail++;
            $display("FAIL underrun_first: got %0d required 1", ucnt);
        end
        for (int k = 0; k < 299; k++) run_frame(17, 17, 1'b0, 32'h0);
        n_tests++;
        if (ucnt !== 8'd255) begin
            n_fail++;
            $display("FAIL underrun_saturate: got %0d required 255", ucnt);
        end
    endtask

    task automatic test_play_drop();
        logic [31:0] s1;
        logic [31:0] s2;
        s1 = $urandom;
        s2 = $urandom;
        load_sample(s1);
        lrck = 1'b0;
        tick();
        m_full = 1'b0;
        valid  = 1'b1;
        data   = s2;
        for (int i = 2; i <= 5; i++) tick();
        n_tests++;
        if (dacdat !== s1[27] || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL play_drop_bit5: dacdat=%b ready=%b required %b 0", dacdat, ready, s1[27]);
        end
        play = 1'b0;
        tick();
        n_tests++;
        if (st !== 3'd0 || dacdat !== 1'b0 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL play_drop_idle: st=%0d dacdat=%b ready=%b required 0 0 0", st, dacdat, ready);
        end
        for (int i = 0; i < 40; i++) begin
            if (i % 10 == 0) lrck = ~lrck;
            tick();
            n_tests++;
            if (st !== 3'd0 || dacdat !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_quiet: i=%0d st=%0d dacdat=%b required 0 0", i, st, dacdat);
            end
        end
        lrck = 1'b1;
        tick();
        play = 1'b1;
        tick();
        run_frame(20, 20, 1'b0, 32'h0);
    endtask

    task automatic test_short_frame();
        load_sample($urandom);
        run_frame(20, 8, 1'b1, $urandom);
        run_frame(20, 20, 1'b0, 32'h0);
    endtask

    task automatic test_valid_held();
        load_sample($urandom);
        valid = 1'b1;
        data  = $urandom;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (ready !== 1'b0 || valid !== 1'b1) begin
                n_fail++;
                $display("FAIL held_no_accept: ready=%b required 0", ready);
            end
        end
        run_frame(20, 20, 1'b0, 32'h0);
        run_frame(20, 20, 1'b0, 32'h0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 25; k++) begin
            run_frame($urandom_range(17, 24), $urandom_range(8, 24), 1'($urandom_range(0, 1)), $urandom);
        end
    endtask

    task automatic test_reset_mid();
        valid = 1'b0;
        if (m_full) run_frame(20, 20, 1'b0, 32'h0);
        load_sample($urandom);
        lrck = 1'b0;
        tick();
        m_full = 1'b0;
        valid  = 1'b1;
        data   = $urandom;
        for (int i = 2; i <= 6; i++) tick();
        rst_n = 1'b0;
        #2;
        n_tests++;
        if (st !== 3'd0 || ready !== 1'b1 || dacdat !== 1'b0 || underrun !== 1'b0 || ucnt !== 8'd0) begin
            n_fail++;
            $display("FAIL async_reset: st=%0d ready=%b dacdat=%b underrun=%b cnt=%0d required 0,1,0,0,0",
                     st, ready, dacdat, underrun, ucnt);
        end
        m_full = 1'b0;
        m_ucnt = 0;
        valid  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (st !== 3'd1 || dacdat !== 1'b0 || underrun !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_wait: st=%0d dacdat=%b underrun=%b required 1 0 0", st, dacdat, underrun);
            end
        end
        lrck = 1'b1;
        tick();
        run_frame(20, 20, 1'b0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_play_drop();
        test_short_frame();
        test_valid_held();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
